aes_load_sequencer: RTL

//  Parametrised control FSM for the AES front end: steps the user through loading IV, message and key words

---
 rtl/aes_seq_pkg.sv | 30 +++
 rtl/aes_seq_timeout.sv | 27 ++
 rtl/aes_load_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared state encoding, field codes and defaults for the AES load sequencer.
package aes_seq_pkg;

    localparam int NWORDS_DEF  = 4;
    localparam int TIMEOUT_DEF = 1000000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_IV_WORD,
        S_MSG_MODE,
        S_MSG_WORD,
        S_KEY_MODE,
        S_KEY_WORD,
        S_ROUND,
        S_ENC_START,
        S_ENC_WAIT,
        S_OUTPUT,
        S_DISPLAY,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {F_NONE, F_IV, F_MSG, F_KEY} field_t;

    function automatic field_t field_of(state_t s);
        return s == S_IV_WORD  ? F_IV  :
               s == S_MSG_WORD ? F_MSG :
               s == S_KEY_WORD ? F_KEY : F_NONE;
    endfunction

endpackage

// File: rtl/aes_seq_timeout.sv
// aes_seq_timeout: cycle counter that flags the last allowed wait cycle; TIMEOUT_CYC=0 never expires.
module aes_seq_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = TIMEOUT_CYC < 2 ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nrst)
        if (!nrst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);

    assign expired = (TIMEOUT_CYC != 0) && (cnt == LAST);

endmodule

// File: rtl/aes_load_sequencer.sv
// aes_load_sequencer: button-driven load/launch FSM for the AES front end.
module aes_load_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NWORDS      = NWORDS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    localparam int IDX_W      = $clog2(NWORDS)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             pb_next,
    input  logic             pb_commit,
    input  logic             pb_back,
    input  logic             mode_cbc,
    input  logic             finished,
    output logic             ld_iv,
    output logic             ld_msg,
    output logic             ld_key,
    output logic [IDX_W-1:0] word_idx,
    output logic             ron,
    output logic             start_enc,
    output logic             enc_busy,
    output logic             out_latch,
    output logic             disp,
    output logic             mode_q,
    output logic             err_timeout
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

    state_t           state, nxt;
    field_t           nf;
    logic [IDX_W-1:0] widx, nxt_idx;
    logic             kv, nxt_kv, nxt_mode, expired;
    logic             bk, cm, nx;

    // back beats commit beats next; losers are simply dropped
    assign bk = pb_back;
    assign cm = pb_commit & ~pb_back;
    assign nx = pb_next & ~pb_back & ~pb_commit;

    aes_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (state == S_ENC_START),
        .en      (state == S_ENC_WAIT),
        .expired (expired)
    );

    always_comb begin
        nxt      = state;
        widx     = word_idx;
        nxt_kv   = kv;
        nxt_mode = mode_q;
        case (state)
            S_IDLE:
                if (nx) begin
                    nxt      = mode_cbc ? S_IV_WORD : S_MSG_MODE;
                    nxt_mode = mode_cbc;
                end
            S_IV_WORD, S_MSG_WORD, S_KEY_WORD:
                if (bk) begin
                    if (word_idx != '0)
                        widx = word_idx - IDX_W'(1);
                    else
                        nxt = state == S_IV_WORD  ? S_IDLE :
                              state == S_MSG_WORD ? S_MSG_MODE : S_KEY_MODE;
                end else if (cm) begin
                    if (word_idx == LAST) begin
                        nxt    = state == S_IV_WORD ? S_MSG_MODE :
                                 ((state == S_KEY_WORD) || kv) ? S_ROUND : S_KEY_MODE;
                        nxt_kv = kv | (state == S_KEY_WORD);
                    end
                end else if (nx && word_idx != LAST)
                    widx = word_idx + IDX_W'(1);
            S_MSG_MODE:
                if (nx) begin
                    nxt  = S_MSG_WORD;
                    widx = '0;
                end else if (bk) begin
                    nxt  = mode_q ? S_IV_WORD : S_IDLE;
                    widx = LAST;
                end
            S_KEY_MODE:
                if (nx) begin
                    nxt  = S_KEY_WORD;
                    widx = '0;
                end else if (bk) begin
                    nxt  = S_MSG_WORD;
                    widx = LAST;
                end
            S_ROUND:
                if (bk) begin
                    nxt    = S_KEY_WORD;
                    widx   = LAST;
                    nxt_kv = 1'b0;
                end else if (cm)
                    nxt = S_ENC_START;
            S_ENC_START: nxt = S_ENC_WAIT;
            S_ENC_WAIT:  nxt = finished ? S_OUTPUT : expired ? S_ERROR : S_ENC_WAIT;
            S_OUTPUT:    nxt = S_DISPLAY;
            S_DISPLAY:
                if (bk) begin
                    nxt    = S_IDLE;
                    nxt_kv = 1'b0;
                end else if (cm)
                    nxt = S_MSG_MODE;
            S_ERROR:
                if (bk || cm) begin
                    nxt    = S_IDLE;
                    nxt_kv = 1'b0;
                end
            default: nxt = S_IDLE;
        endcase
        nf      = field_of(nxt);
        nxt_idx = nf == F_NONE ? '0 : widx;
    end

    // outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            mode_q      <= 1'b0;
            kv          <= 1'b0;
            ld_iv       <= 1'b0;
            ld_msg      <= 1'b0;
            ld_key      <= 1'b0;
            ron         <= 1'b0;
            start_enc   <= 1'b0;
            enc_busy    <= 1'b0;
            out_latch   <= 1'b0;
            disp        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= nxt;
            word_idx    <= nxt_idx;
            mode_q      <= nxt_mode;
            kv          <= nxt_kv;
            ld_iv       <= nf == F_IV;
            ld_msg      <= nf == F_MSG;
            ld_key      <= nf == F_KEY;
            ron         <= nxt == S_ROUND;
            start_enc   <= nxt == S_ENC_START;
            enc_busy    <= nxt == S_ENC_WAIT;
            out_latch   <= nxt == S_OUTPUT;
            disp        <= nxt == S_DISPLAY;
            err_timeout <= nxt == S_ERROR;
        end

endmodule
